// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory (combinational read, posedge write).
// Optional atomic lock sequences are compiled in with `define MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic          mem_write_en,
  output logic          mem_read_en,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state;
  logic   rr_ptr;
  logic   sel0;
  logic   sel1;

`ifndef MEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  // Grant decision; a lock owner is the only candidate while its lock is held.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !rr_ptr)) sel0 = 1'b1;
        else if (req1)                  sel1 = 1'b1;
      end
`ifdef MEM_ARB_LOCK_EN
      LOCK0: sel0 = req0;
      LOCK1: sel1 = req1;
`endif
      default: ;
    endcase
  end

  assign gnt0 = rst_n & sel0;
  assign gnt1 = rst_n & sel1;
  assign busy = gnt0 | gnt1;

  always_comb begin
    mem_address  = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    if (gnt0) begin
      mem_address  = addr0;
      mem_wdata    = wdata0;
      mem_write_en = we0;
      mem_read_en  = ~we0;
    end else if (gnt1) begin
      mem_address  = addr1;
      mem_wdata    = wdata1;
      mem_write_en = we1;
      mem_read_en  = ~we1;
    end
  end

  // Read return stage and arbitration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
      case (state)
        IDLE: begin
          if (gnt0)      rr_ptr <= 1'b1;
          else if (gnt1) rr_ptr <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
          if (gnt0 && lock0)      state <= LOCK0;
          else if (gnt1 && lock1) state <= LOCK1;
`endif
        end
`ifdef MEM_ARB_LOCK_EN
        // Pointer is frozen inside a lock and hands priority over on exit.
        LOCK0: if (!req0 || !lock0) begin
          state  <= IDLE;
          rr_ptr <= 1'b1;
        end
        LOCK1: if (!req1 || !lock1) begin
          state  <= IDLE;
          rr_ptr <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
